// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bundle of every non-clock signal between the decode/execute/memory stages
// (master) and the scoreboarded register file (slave).
//   rd_addr    : NUM_RD flattened read addresses (port 0 in the LSBs)
//   rd_data    : NUM_RD flattened read data, bypassed
//   rd_busy    : per read port, the register has an outstanding load
//   wr_*       : ALU write port
//   ld_issue*  : load issue, marks the destination register busy
//   ld_wb_*    : load writeback port
//   busy_vec   : registered busy bits, one per register
//   pend_cnt   : registered popcount of busy_vec
//   hazard_err : sticky protocol error flag
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 3
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     ld_issue;
  logic [ADDR_W-1:0]        ld_issue_addr;
  logic                     ld_wb_en;
  logic [ADDR_W-1:0]        ld_wb_addr;
  logic [DATA_W-1:0]        ld_wb_data;
  logic [2**ADDR_W-1:0]     busy_vec;
  logic [ADDR_W:0]          pend_cnt;
  logic                     hazard_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output ld_issue, ld_issue_addr, ld_wb_en, ld_wb_addr, ld_wb_data,
    input  rd_data, rd_busy, busy_vec, pend_cnt, hazard_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  ld_issue, ld_issue_addr, ld_wb_en, ld_wb_addr, ld_wb_data,
    output rd_data, rd_busy, busy_vec, pend_cnt, hazard_err
  );
endinterface

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Parametrised register file with two write ports (ALU and load writeback),
// same-cycle read bypass, a hardwired null register and a load scoreboard
// that flags hazards to the decoder.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset, clears all state
//   bus : regfile_sb_if.slave, read/write/load/scoreboard signals
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int               DATA_W    = 16,
  parameter int               ADDR_W    = 3,
  parameter int               NUM_RD    = 3,
  parameter int               NULL_REG  = 7,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int               DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] NULL_A = ADDR_W'(NULL_REG);

  logic [DATA_W-1:0]        r_regs [DEPTH];
  logic [DEPTH-1:0]         r_busy;
  logic [DEPTH-1:0]         w_busy_next;
  logic [ADDR_W:0]          r_pend_cnt;
  logic [ADDR_W:0]          w_pend_next;
  logic                     r_hazard_err;
  logic                     w_wr_ok;
  logic                     w_wb_ok;
  logic                     w_err_issue;
  logic                     w_err_wb;
  logic                     w_err_waw;
  logic [NUM_RD*DATA_W-1:0] w_rd_flat;
  logic [NUM_RD-1:0]        w_rd_busy;

  // Writes to the null register are dropped at the source.
  assign w_wr_ok = bus.wr_en    && (bus.wr_addr    != NULL_A);
  assign w_wb_ok = bus.ld_wb_en && (bus.ld_wb_addr != NULL_A);

  // Storage. The load writeback is assigned last so it wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= RESET_VAL;
    end else begin
      if (w_wr_ok) r_regs[bus.wr_addr]    <= bus.wr_data;
      if (w_wb_ok) r_regs[bus.ld_wb_addr] <= bus.ld_wb_data;
    end
  end

  // Next busy state per register: a new issue beats a writeback so that an
  // issue and writeback to the same register leave the new load outstanding.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      if (gi == NULL_REG) begin : g_null
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign w_busy_next[gi] =
          (bus.ld_issue && (bus.ld_issue_addr == ADDR_W'(gi))) ||
          (r_busy[gi] && !(bus.ld_wb_en && (bus.ld_wb_addr == ADDR_W'(gi))));
      end
    end
  endgenerate

  // Count is taken from the next busy state so it stays aligned with busy_vec.
  always_comb begin
    w_pend_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_pend_next = w_pend_next + (ADDR_W+1)'(w_busy_next[k]);
    end
  end

  // Protocol errors. r_busy of the null register is always 0, so issues to
  // and writes of the null register never raise an error on their own.
  assign w_err_issue = bus.ld_issue && r_busy[bus.ld_issue_addr] &&
                       !(bus.ld_wb_en && (bus.ld_wb_addr == bus.ld_issue_addr));
  assign w_err_wb    = w_wb_ok && !r_busy[bus.ld_wb_addr];
  assign w_err_waw   = bus.wr_en && r_busy[bus.wr_addr] &&
                       !(bus.ld_wb_en && (bus.ld_wb_addr == bus.wr_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= '0;
      r_pend_cnt   <= '0;
      r_hazard_err <= 1'b0;
    end else begin
      r_busy       <= w_busy_next;
      r_pend_cnt   <= w_pend_next;
      r_hazard_err <= r_hazard_err | w_err_issue | w_err_wb | w_err_waw;
    end
  end

  // Read ports. Bypass is suppressed while reset is held so reads return the
  // reset contents rather than data that will never be written.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_hit_wb;
      logic              w_hit_wr;

      assign w_addr   = bus.rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_hit_wb = !rst && bus.ld_wb_en && (bus.ld_wb_addr == w_addr);
      assign w_hit_wr = !rst && bus.wr_en    && (bus.wr_addr    == w_addr);

      assign w_rd_flat[gi*DATA_W +: DATA_W] =
        (w_addr == NULL_A) ? '0 :
        w_hit_wb           ? bus.ld_wb_data :
        w_hit_wr           ? bus.wr_data :
                             r_regs[w_addr];

      // Data arriving this cycle means the consumer need not stall.
      assign w_rd_busy[gi] = r_busy[w_addr] && !w_hit_wb;
    end
  endgenerate

  assign bus.rd_data    = w_rd_flat;
  assign bus.rd_busy    = w_rd_busy;
  assign bus.busy_vec   = r_busy;
  assign bus.pend_cnt   = r_pend_cnt;
  assign bus.hazard_err = r_hazard_err;
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the pipelined core. It is the successor to the fixed 8x16 file. It provides:
- configurable data width, depth and read-port count;
- two write ports (ALU result and load writeback) with same-cycle bypass;
- a hardwired null register;
- a load scoreboard that tracks outstanding loads per register and flags hazards to the decoder.

It sits between decode (reads, load issue) and execute/memory (writes).

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; depth = 2**ADDR_W
- NUM_RD, 3, number of read ports (port 0 in LSBs of flattened buses)
- NULL_REG, 7, register index whose writes are discarded, reads 0, never busy
- RESET_VAL, 0, value loaded into every register on reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rd_addr  in  NUM_RD*ADDR_W  read addresses
- rd_data  out  NUM_RD*DATA_W  read data, bypassed
- rd_busy  out  NUM_RD  read port targets a register with an outstanding load
- wr_en  in  1  ALU write enable
- wr_addr  in  ADDR_W  ALU write address
- wr_data  in  DATA_W  ALU write data
- ld_issue  in  1  load issued; marks ld_issue_addr busy
- ld_issue_addr  in  ADDR_W  load destination
- ld_wb_en  in  1  load writeback enable
- ld_wb_addr  in  ADDR_W  load writeback address
- ld_wb_data  in  DATA_W  load data
- busy_vec  out  2**ADDR_W  registered busy bits, one per register
- pend_cnt  out  ADDR_W+1  number of set busy bits
- hazard_err  out  1  sticky protocol error

## Operation
- **Write:** on clk, if wr_en && wr_addr!=NULL_REG, then regs[wr_addr]<=wr_data. If ld_wb_en && ld_wb_addr!=NULL_REG, then regs[ld_wb_addr]<=ld_wb_data.
- **Write collision:** both ports target the same address → the load writeback wins.
- **Read, per port i:**
  - rd_addr_i==NULL_REG → 0.
  - Else ld_wb_en && ld_wb_addr==rd_addr_i → ld_wb_data.
  - Else wr_en && wr_addr==rd_addr_i → wr_data.
  - Else regs[rd_addr_i].
- **Scoreboard, next busy[a]:**
  - Set if ld_issue && ld_issue_addr==a.
  - Otherwise cleared if ld_wb_en && ld_wb_addr==a.
  - Otherwise held.
  - Issue and writeback to the same address in one cycle leaves busy set (new load outstanding).
  - busy[NULL_REG] is constantly 0; issues to NULL_REG are ignored.
- **rd_busy_i** = busy[rd_addr_i] && !(ld_wb_en && ld_wb_addr==rd_addr_i). This is combinational; a register whose data is arriving this cycle reads as not busy.
- **pend_cnt** = popcount(busy_vec), registered alongside busy_vec.
- **hazard_err** sets on the clock edge following any of these. It stays set until reset.
  - ld_issue to a register already busy that is not cleared in the same cycle.
  - ld_wb_en to a non-null register that is not busy.
  - wr_en to a busy register that is not being written back by load in the same cycle (WAW hazard).
- Errors do not block the writes themselves; data and busy updates proceed as above.

## Timing
- Reset asserted: regs=RESET_VAL, busy_vec=0, pend_cnt=0, hazard_err=0, all immediately (async).
- While reset is high:
  - writes and issues are ignored;
  - rd_data returns RESET_VAL (0 for NULL_REG);
  - rd_busy=0.
- Reset released mid-load: the scoreboard is empty. A late ld_wb after release raises hazard_err and still writes data.
- Write-to-read through the array: 1 cycle. Write-to-read through the bypass: 0 cycles, same cycle.
- ld_issue → busy_vec bit and rd_busy visible the next cycle.
- ld_wb → rd_busy clears the same cycle; busy_vec clears the next cycle.
- pend_cnt range 0..2**ADDR_W-1. No wrap is possible because NULL_REG is never counted.

## Test plan
- **Reset and null register:** reset pulse mid-run, then read all addresses → every non-null register reads RESET_VAL (0) and all registered outputs read 0. Then wr_en=1 to addr 7 with data 16'hBEEF → read of addr 7 stays 0.
- **Bypass priority:** same cycle, wr_en addr 2 = 16'h1111 and ld_wb addr 2 = 16'h2222 (reg 2 busy) → all ports reading 2 show 16'h2222 that cycle. Next cycle the array holds 16'h2222 and busy[2]=0.
- **Scoreboard:**
  - Issue loads to regs 1, 3 and 5 on consecutive cycles → pend_cnt steps 1, 2, 3 and busy_vec=8'b00101010.
  - rd_busy is 1 on a port reading 3.
  - ld_wb addr 3 → that cycle rd_busy=0 with data forwarded; next cycle pend_cnt=2.
- **Simultaneous issue and writeback:** reg 4 busy, then ld_issue addr 4 and ld_wb addr 4 in the same cycle → busy[4] stays 1, hazard_err stays 0, and reg 4 holds the wb data.
- **Errors:** ld_wb to idle reg 6 → hazard_err=1 the next cycle and persists. wr_en to busy reg 1 after a reset → also sets it. Reset clears it.
- **Parametrisation:** DATA_W=32, ADDR_W=4, NUM_RD=4, NULL_REG=0 → repeat the bypass and scoreboard tests; pend_cnt reaches 15 with all non-null registers busy.
